rvfpm_xreg_issue: RTL and testbench
===================================

// Module: rvfpm_xreg_issue
// PURPOSE
//  Integer-core side of the rvfpm X-register interface. Accepts FP instructions from the core and
//  issues them to rvfpm as instruction/enable with rs1 data on data_fromXReg. Tracks X-writing ops
//  through a PIPELINE_STAGES-deep tag pipe and returns data_toXReg to the core as a writeback.
//  Counterpart to the FMV.X.W result path that the rvfpm bench checks.
// PARAMETERS
//  PIPELINE_STAGES  4   rvfpm latency in cycles from an issue cycle to its data_toXReg sample; >=1
//  XLEN            32   integer data width; equals FP register width
// PORTS
//  ck                 in   1     clock, rising edge
//  rst                in   1     asynchronous reset, active-low
//  instr_valid        in   1     core offers an instruction
//  instr_ready        out  1     block accepts it; transfer when instr_valid && instr_ready
//  instruction        in   32    RV32F instruction word
//  rs1_data           in   XLEN  integer rs1 value for this instruction
//  fpu_stall          in   1     rvfpm cannot take an issue this cycle
//  fpu_enable         out  1     issue strobe; the rvfpm pipeline advances when high
//  fpu_instruction    out  32    instruction to rvfpm; 32'h0 (NOP) when nothing is issued
//  fpu_data_fromXReg  out  XLEN  rs1_data registered with the instruction
//  data_toXReg        in   XLEN  rvfpm integer result
//  wb_valid           out  1     one-cycle writeback pulse
//  wb_rd              out  5     destination X register
//  wb_data            out  XLEN  result captured from data_toXReg
// BEHAVIOUR
//  - Reset values: instr_ready=0, fpu_enable=0, fpu_instruction=0, fpu_data_fromXReg=0,
//    wb_valid=0, wb_rd=0, wb_data=0, and all tag-pipe valids cleared.
//  - instr_ready=1 when !fpu_stall and no hazard exists (see CONFIGURATION). It is combinational
//    from these inputs and the tag pipe, and is forced to 0 while in reset.
//  - Issue register: it loads on every cycle where !fpu_stall.
//    On an accepted transfer it takes the instruction and rs1_data; otherwise it takes NOP and
//    data 0. fpu_enable is a registered copy of !fpu_stall.
//    Accept-to-fpu_instruction latency is 1 cycle.
//  - Decode (opcode 7'b1010011) marks an X-writer when funct7 is one of:
//    7'b1110000 (FMV.X.W / FCLASS), 7'b1100000 (FCVT.W[U].S), 7'b1010000 (FEQ/FLT/FLE).
//    A writer with rd=0 is tagged invalid. X-readers are funct7 7'b1111000 (FMV.W.X) and
//    7'b1101000 (FCVT.S.W[U]).
//  - Tag pipe: PIPELINE_STAGES entries of {valid, rd}. It shifts only on cycles with fpu_enable=1.
//    Stage 0 loads the tag of the instruction currently on fpu_instruction.
//  - When the last stage is valid and fpu_enable=1: on the next edge wb_valid=1, wb_rd=tag.rd and
//    wb_data=data_toXReg. Otherwise wb_valid=0 and wb_rd/wb_data hold their values.
//  - Writeback latency is 1+PIPELINE_STAGES+1 cycles after acceptance when there is no stall.
//    Each fpu_stall cycle adds 1.
//  - Simultaneous accept and writeback in the same cycle are both performed.
//    Back-to-back issue sustains 1 instruction per cycle.
//  - Asserting rst mid-operation discards in-flight tags, and no writeback is produced for them.
//    After release, the first accept is possible on the first edge with rst high.
// CONFIGURATION
//  RVFPM_HAZARD_STALL_EN defined:
//    An X-reader is held off (instr_ready=0) while rs1 equals the rd of any valid tag, and while it
//    equals the rd of the writer currently in the issue register. The hold is released the cycle
//    after the matching wb_valid.
//  RVFPM_HAZARD_STALL_EN undefined:
//    No hazard check; instr_ready = !fpu_stall. The core owns RAW ordering.
// STRUCTURE
//  rvfpm_xreg_pkg:
//    - typedef xtag_t {logic valid; logic [4:0] rd;}
//    - localparams OPC_OP_FP, F7_FMV_X_W, F7_FCVT_W_S, F7_FCMP, F7_FMV_W_X, F7_FCVT_S_W, NOP_INSTR
//    - function is_xwriter()
//    - function is_xreader()
//  Sub-module rvfpm_xreg_tagpipe: enable-gated shift register of xtag_t with a per-stage rd-match
//  vector output.
// TESTING
//  1. Reset values: hold rst=0 for 3 cycles while driving instr_valid=1.
//     -> All outputs 0 and no acceptance; after release, instr_ready=1.
//  2. FMV.X.W: issue 32'hE0008553 (rd=x10, fs1=f1) with the bench forcing data_toXReg=32'h3F800000
//     at the sample cycle. -> wb_valid pulse after PIPELINE_STAGES+2 cycles,
//     wb_rd=10, wb_data=32'h3F800000.
//  3. Throughput: issue 4 back-to-back FEQ.S with rd=x1..x4.
//     -> 4 consecutive wb_valid pulses with wb_rd=1,2,3,4 in order.
//  4. fpu_stall: assert it for 2 cycles mid-flight. -> fpu_enable=0 for those 2 cycles,
//     writeback delayed by exactly 2 cycles, tags not lost or duplicated.
//  5. Hazard (EN defined): FMV.X.W to x5, then FMV.W.X reading x5.
//     -> instr_ready=0 until the cycle after wb_valid with wb_rd=5, then accepted.
//     With EN undefined, it is accepted immediately.
//  6. Reset mid-flight: pull rst low while 3 writers are pending.
//     -> wb_valid never pulses for them, and the pipe is empty after release.

Source files
------------

// File: rtl/rvfpm_xreg_pkg.sv
// rvfpm X-register interface: shared tag type, OP-FP decode constants and
// the X-writer / X-reader classification used by the issue block.
package rvfpm_xreg_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } xtag_t;

    localparam logic [6:0]  OPC_OP_FP   = 7'b1010011;
    localparam logic [6:0]  F7_FMV_X_W  = 7'b1110000;  // FMV.X.W / FCLASS.S
    localparam logic [6:0]  F7_FCVT_W_S = 7'b1100000;  // FCVT.W[U].S
    localparam logic [6:0]  F7_FCMP     = 7'b1010000;  // FEQ/FLT/FLE.S
    localparam logic [6:0]  F7_FMV_W_X  = 7'b1111000;  // FMV.W.X
    localparam logic [6:0]  F7_FCVT_S_W = 7'b1101000;  // FCVT.S.W[U]
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    // Instruction returns a result to the integer register file.
    function automatic logic is_xwriter(input logic [31:0] instr);
        logic [6:0] f7;
        f7 = instr[31:25];
        return (instr[6:0] == OPC_OP_FP) &&
               ((f7 == F7_FMV_X_W) || (f7 == F7_FCVT_W_S) || (f7 == F7_FCMP));
    endfunction

    // Instruction consumes an integer rs1 operand.
    function automatic logic is_xreader(input logic [31:0] instr);
        logic [6:0] f7;
        f7 = instr[31:25];
        return (instr[6:0] == OPC_OP_FP) &&
               ((f7 == F7_FMV_W_X) || (f7 == F7_FCVT_S_W));
    endfunction

    // Writers targeting x0 produce no writeback, so they carry an invalid tag.
    function automatic xtag_t make_xtag(input logic [31:0] instr);
        xtag_t t;
        t.rd    = instr[11:7];
        t.valid = is_xwriter(instr) && (instr[11:7] != 5'd0);
        return t;
    endfunction

endpackage

// File: rtl/rvfpm_xreg_tagpipe.sv
// Enable-gated shift register of writeback tags tracking X-writers through
// the rvfpm pipeline, with a per-stage destination match against match_rd.
module rvfpm_xreg_tagpipe
    import rvfpm_xreg_pkg::*;
#(
    parameter int unsigned STAGES = 4
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              shift_en,
    input  xtag_t             tag_in,
    input  logic [4:0]        match_rd,
    output xtag_t             tag_last,
    output logic [STAGES-1:0] match_vec
);

    xtag_t tags_q [STAGES];
    xtag_t tags_d [STAGES];

    // Shift one stage per enabled rvfpm cycle, hold otherwise.
    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) tags_d[i] = tags_q[i];
        if (shift_en) begin
            tags_d[0] = tag_in;
            for (int unsigned i = 1; i < STAGES; i++) tags_d[i] = tags_q[i-1];
        end
    end

    // Tag storage; reset discards every in-flight tag.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < STAGES; i++) tags_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) tags_q[i] <= tags_d[i];
        end
    end

    // Flag stages holding a valid writer to match_rd.
    always_comb begin
        match_vec = '0;
        for (int unsigned i = 0; i < STAGES; i++)
            match_vec[i] = tags_q[i].valid && (tags_q[i].rd == match_rd);
    end

    assign tag_last = tags_q[STAGES-1];

endmodule

// File: rtl/rvfpm_xreg_issue.sv
// Integer-core side of the rvfpm X-register interface: issues FP instructions
// with rs1 data to rvfpm and returns data_toXReg as a writeback to the core.
// Optional feature: define RVFPM_HAZARD_STALL_EN to hold off X-readers whose
// rs1 is still pending from an in-flight X-writer.
module rvfpm_xreg_issue
    import rvfpm_xreg_pkg::*;
#(
    parameter int unsigned PIPELINE_STAGES = 4,
    parameter int unsigned XLEN            = 32
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            fpu_stall,
    output logic            fpu_enable,
    output logic [31:0]     fpu_instruction,
    output logic [XLEN-1:0] fpu_data_fromXReg,
    input  logic [XLEN-1:0] data_toXReg,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    logic            fpu_enable_q, fpu_enable_d;
    logic [31:0]     fpu_instr_q,  fpu_instr_d;
    logic [XLEN-1:0] fpu_data_q,   fpu_data_d;
    logic            wb_valid_q,   wb_valid_d;
    logic [4:0]      wb_rd_q,      wb_rd_d;
    logic [XLEN-1:0] wb_data_q,    wb_data_d;

    xtag_t                      issue_tag;
    xtag_t                      tag_last;
    logic [PIPELINE_STAGES-1:0] tag_match;
    logic                       hazard;
    logic                       accept;

    assign issue_tag = make_xtag(fpu_instr_q);

    rvfpm_xreg_tagpipe #(
        .STAGES (PIPELINE_STAGES)
    ) u_tagpipe (
        .ck        (ck),
        .rst       (rst),
        .shift_en  (fpu_enable_q),
        .tag_in    (issue_tag),
        .match_rd  (instruction[19:15]),
        .tag_last  (tag_last),
        .match_vec (tag_match)
    );

`ifdef RVFPM_HAZARD_STALL_EN
    // The writeback cycle itself still blocks: the core register file only
    // holds the new value from the following cycle.
    always_comb begin
        hazard = 1'b0;
        if (is_xreader(instruction)) begin
            hazard = (|tag_match) ||
                     (issue_tag.valid && (issue_tag.rd == instruction[19:15])) ||
                     (wb_valid_q && (wb_rd_q == instruction[19:15]));
        end
    end
`else
    logic unused_match;
    assign unused_match = ^tag_match;
    assign hazard       = 1'b0;
`endif

    assign instr_ready = rst && !fpu_stall && !hazard;
    assign accept      = instr_valid && instr_ready;

    // Issue register: reload every unstalled cycle with the accepted op or a NOP.
    always_comb begin
        fpu_enable_d = !fpu_stall;
        fpu_instr_d  = fpu_instr_q;
        fpu_data_d   = fpu_data_q;
        if (!fpu_stall) begin
            if (accept) begin
                fpu_instr_d = instruction;
                fpu_data_d  = rs1_data;
            end else begin
                fpu_instr_d = NOP_INSTR;
                fpu_data_d  = '0;
            end
        end
    end

    // Writeback capture when a valid tag leaves the last stage.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (fpu_enable_q && tag_last.valid) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = tag_last.rd;
            wb_data_d  = data_toXReg;
        end
    end

    // Output registers.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            fpu_enable_q <= 1'b0;
            fpu_instr_q  <= NOP_INSTR;
            fpu_data_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            fpu_enable_q <= fpu_enable_d;
            fpu_instr_q  <= fpu_instr_d;
            fpu_data_q   <= fpu_data_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign fpu_enable        = fpu_enable_q;
    assign fpu_instruction   = fpu_instr_q;
    assign fpu_data_fromXReg = fpu_data_q;
    assign wb_valid          = wb_valid_q;
    assign wb_rd             = wb_rd_q;
    assign wb_data           = wb_data_q;

endmodule

// File: tb/tb_rvfpm_xreg_issue.sv
// Directed bench for rvfpm_xreg_issue (PIPELINE_STAGES=4, XLEN=32).
// Honours RVFPM_HAZARD_STALL_EN for the reader-after-writer case.
`timescale 1ns/1ps
module tb_rvfpm_xreg_issue;

    localparam int unsigned S = 4;
`ifdef RVFPM_HAZARD_STALL_EN
    localparam int HZ_REL = S + 3;
`else
    localparam int HZ_REL = 1;
`endif

    localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
    localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
    localparam logic [6:0] F7_FCMP     = 7'b1010000;
    localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = '0;
    logic [31:0] rs1_data = '0;
    logic        fpu_stall = 1'b0;
    logic        fpu_enable;
    logic [31:0] fpu_instruction;
    logic [31:0] fpu_data_fromXReg;
    logic [31:0] data_toXReg = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    rvfpm_xreg_issue #(
        .PIPELINE_STAGES (S),
        .XLEN            (32)
    ) dut (
        .ck                (ck),
        .rst               (rst),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instruction       (instruction),
        .rs1_data          (rs1_data),
        .fpu_stall         (fpu_stall),
        .fpu_enable        (fpu_enable),
        .fpu_instruction   (fpu_instruction),
        .fpu_data_fromXReg (fpu_data_fromXReg),
        .data_toXReg       (data_toXReg),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] op_fp(input logic [6:0] f7, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd0, rs1, f3, rd, 7'b1010011};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_v;
        int   acc_at;
        int   wb_seen;

        // 1. Reset values with the core already offering an instruction
        #1 rst = 1'b0;
        instr_valid = 1'b1;
        instruction = 32'hE0008553;
        rs1_data    = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ready", instr_ready, 0);
        end
        check("rst_fpu_enable", fpu_enable, 0);
        check("rst_fpu_instr", fpu_instruction, 0);
        check("rst_fpu_data", fpu_data_fromXReg, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        instr_valid = 1'b0;
        rst = 1'b1;
        #1 check("post_rst_ready", instr_ready, 1);

        // 2. FMV.X.W x10, f1 with result 1.0f at the sample cycle
        step();
        instruction = 32'hE0008553;
        rs1_data    = 32'h1234_5678;
        instr_valid = 1'b1;
        data_toXReg = 32'hDEAD_BEEF;
        #1 check("t2_ready", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        check("t2_fpu_instr", fpu_instruction, 32'hE0008553);
        check("t2_fpu_data", fpu_data_fromXReg, 32'h1234_5678);
        check("t2_fpu_enable", fpu_enable, 1);
        for (int j = 1; j <= int'(S) + 2; j++) begin
            data_toXReg = (j == int'(S) + 1) ? 32'h3F80_0000 : 32'hDEAD_BEEF;
            step();
            exp_v = (j == int'(S) + 1);
            check("t2_wb_valid", wb_valid, exp_v);
            if (j == 1) check("t2_nop_after", fpu_instruction, 0);
            if (exp_v) begin
                check("t2_wb_rd", wb_rd, 10);
                check("t2_wb_data", wb_data, 32'h3F80_0000);
            end
        end
        check("t2_wb_rd_hold", wb_rd, 10);
        check("t2_wb_data_hold", wb_data, 32'h3F80_0000);
        idle(2);

        // 3. Four back-to-back FEQ.S, rd = x1..x4
        for (int j = 0; j <= int'(S) + 6; j++) begin
            instr_valid = (j < 4);
            instruction = op_fp(F7_FCMP, 5'(j + 1), 3'b010, 5'(j + 1));
            data_toXReg = 32'hC000_0000 + j;
            #1 if (j < 4) check("t3_ready", instr_ready, 1);
            step();
            exp_v = (j >= int'(S) + 1) && (j <= int'(S) + 4);
            check("t3_wb_valid", wb_valid, exp_v);
            if (exp_v) begin
                check("t3_wb_rd", wb_rd, j - int'(S));
                check("t3_wb_data", wb_data, 32'hC000_0000 + j);
            end
        end
        idle(2);

        // 4. Two writers (x7, x8) with a 2-cycle fpu_stall mid-flight
        for (int j = 0; j <= int'(S) + 6; j++) begin
            logic st;
            st          = (j == 2) || (j == 3);
            instr_valid = (j < 2);
            instruction = op_fp(F7_FMV_X_W, 5'd2, 3'b000, 5'(7 + j));
            fpu_stall   = st;
            data_toXReg = 32'hB000_0000 + j;
            #1 check("t4_ready", instr_ready, !st);
            step();
            check("t4_enable", fpu_enable, !st);
            exp_v = (j == int'(S) + 3) || (j == int'(S) + 4);
            check("t4_wb_valid", wb_valid, exp_v);
            if (exp_v) begin
                check("t4_wb_rd", wb_rd, 7 + j - int'(S) - 3);
                check("t4_wb_data", wb_data, 32'hB000_0000 + j);
            end
        end
        fpu_stall = 1'b0;
        idle(2);

        // 5. FMV.X.W x5 followed by FMV.W.X reading x5
        acc_at = -1;
        for (int j = 0; j < 20; j++) begin
            if (j == 0) begin
                instr_valid = 1'b1;
                instruction = op_fp(F7_FMV_X_W, 5'd3, 3'b000, 5'd5);
            end else begin
                instr_valid = (acc_at < 0);
                instruction = op_fp(F7_FMV_W_X, 5'd5, 3'b000, 5'd9);
            end
            data_toXReg = 32'hA5A5_0000 + j;
            #1;
            if (j >= 1 && acc_at < 0) begin
                check("t5_ready", instr_ready, j >= HZ_REL);
                if (instr_ready) acc_at = j;
            end
            step();
            if (j == int'(S) + 1) begin
                check("t5_wb_valid", wb_valid, 1);
                check("t5_wb_rd", wb_rd, 5);
            end
            if (acc_at == j) check("t5_reader_issued", fpu_instruction, op_fp(F7_FMV_W_X, 5'd5, 3'b000, 5'd9));
        end
        check("t5_accept_cycle", acc_at, HZ_REL);
        idle(2);

        // 6. Reset while three writers (x11..x13) are in flight
        for (int j = 0; j < 3; j++) begin
            instr_valid = 1'b1;
            instruction = op_fp(F7_FCVT_W_S, 5'd1, 3'b000, 5'(11 + j));
            step();
        end
        instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("t6_rst_enable", fpu_enable, 0);
        check("t6_rst_instr", fpu_instruction, 0);
        check("t6_rst_ready", instr_ready, 0);
        step();
        step();
        rst = 1'b1;
        wb_seen = 0;
        for (int j = 0; j < int'(S) + 4; j++) begin
            step();
            if (wb_valid) wb_seen++;
        end
        check("t6_no_wb", wb_seen, 0);
        check("t6_wb_rd_cleared", wb_rd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
